mux2to1_arbiter: RTL and testbench

MUX2TO1_ARBITER -- requirements
Module: mux2to1_arbiter

---
 rtl/mux2to1_arbiter_pkg.sv | 15 +
 rtl/mux2to1_arbiter_if.sv | 30 +++
 rtl/mux2to1_arbiter_mux2to1.sv | 13 +
 rtl/mux2to1_arbiter.sv | 98 +++++++++
 tb/tb_mux2to1_arbiter.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/mux2to1_arbiter_pkg.sv
// Shared types and constants for the two-input arbitrating mux.
// Holds the output-register state type, source encodings and default width.
package mux2to1_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/mux2to1_arbiter_if.sv
// Handshake bundle for the arbiter: two producer channels (a, b) and one consumer (y).
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface mux2to1_arbiter_if
  import mux2to1_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             y_valid;
  logic [WIDTH-1:0] y_data;
  logic             y_ready;
  logic             sel;

  modport slave (
    input  a_valid, a_data, b_valid, b_data, y_ready,
    output a_ready, b_ready, y_valid, y_data, sel
  );

  modport master (
    output a_valid, a_data, b_valid, b_data, y_ready,
    input  a_ready, b_ready, y_valid, y_data, sel
  );

endinterface

// File: rtl/mux2to1_arbiter_mux2to1.sv
// Plain combinational 2:1 data selector used in front of the arbiter's output register.
module mux2to1 #(
  parameter int WIDTH = 8
) (
  input  logic             sel_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/mux2to1_arbiter.sv
// Arbitrates two valid/ready channels into a single registered output word.
// FAIR=1 alternates on contention, FAIR=0 always favours channel a.
module mux2to1_arbiter
  import mux2to1_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter bit FAIR  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  mux2to1_arbiter_if.slave  bus
);

  state_t           state_q, state_d;
  logic             lastSrc_q, lastSrc_d;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] yData_q, yData_d;

  logic             grant;
  logic             loadEn;
  logic             anyValid;
  logic             accept;
  logic [WIDTH-1:0] muxData;

  // On a tie the channel that did not win last time gets the slot.
  always_comb begin
    grant = SRC_A;
    if (bus.b_valid && !bus.a_valid) begin
      grant = SRC_B;
    end else if (bus.a_valid && bus.b_valid && FAIR && (lastSrc_q == SRC_A)) begin
      grant = SRC_B;
    end
  end

  assign anyValid = bus.a_valid | bus.b_valid;
  assign loadEn   = !rst && ((state_q == EMPTY) || bus.y_ready);
  assign accept   = loadEn && anyValid;

  mux2to1 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .sel_i (grant),
    .d0_i  (bus.a_data),
    .d1_i  (bus.b_data),
    .y_o   (muxData)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (bus.y_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    bus.y_valid = (state_q == FULL);
    bus.a_ready = loadEn && (grant == SRC_A);
    bus.b_ready = loadEn && (grant == SRC_B);
  end

  // Payload, source tag and fairness history only move when a word is taken.
  always_comb begin
    yData_d   = yData_q;
    sel_d     = sel_q;
    lastSrc_d = lastSrc_q;
    if (accept) begin
      yData_d   = muxData;
      sel_d     = grant;
      lastSrc_d = grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      yData_q   <= '0;
      sel_q     <= SRC_A;
      lastSrc_q <= SRC_B;
    end else begin
      yData_q   <= yData_d;
      sel_q     <= sel_d;
      lastSrc_q <= lastSrc_d;
    end
  end

  assign bus.y_data = yData_q;
  assign bus.sel    = sel_q;

endmodule

// File: tb/tb_mux2to1_arbiter.sv
// Directed self-checking bench: a round-robin instance and a fixed-priority instance
// share clock and reset; expected values are hand-computed constants.
module tb_mux2to1_arbiter;

  logic clk;
  logic rst;

  int total;
  int bad;

  mux2to1_arbiter_if #(.WIDTH(8)) busF ();
  mux2to1_arbiter_if #(.WIDTH(8)) busX ();

  mux2to1_arbiter #(
    .WIDTH (8),
    .FAIR  (1'b1)
  ) dutFair (
    .clk (clk),
    .rst (rst),
    .bus (busF.slave)
  );

  mux2to1_arbiter #(
    .WIDTH (8),
    .FAIR  (1'b0)
  ) dutFixed (
    .clk (clk),
    .rst (rst),
    .bus (busX.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one instance's inputs and let combinational outputs settle.
  task automatic applyStimulus(input bit fixed, input logic av, input logic [7:0] ad,
                               input logic bv, input logic [7:0] bd, input logic yr);
    if (fixed) begin
      busX.a_valid = av; busX.a_data = ad;
      busX.b_valid = bv; busX.b_data = bd;
      busX.y_ready = yr;
    end else begin
      busF.a_valid = av; busF.a_data = ad;
      busF.b_valid = bv; busF.b_data = bd;
      busF.y_ready = yr;
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1);

    // Reset state, with a valid word already offered
    checkOutput("rst_y_valid", {31'b0, busF.y_valid}, 32'h0);
    checkOutput("rst_y_data",  {24'b0, busF.y_data},  32'h0);
    checkOutput("rst_sel",     {31'b0, busF.sel},     32'h0);
    checkOutput("rst_a_ready", {31'b0, busF.a_ready}, 32'h0);
    tick();
    checkOutput("rst_hold_y_valid", {31'b0, busF.y_valid}, 32'h0);

    rst = 1'b0;
    #1;
    checkOutput("post_rst_a_ready", {31'b0, busF.a_ready}, 32'h1);
    tick();
    checkOutput("single_y_valid", {31'b0, busF.y_valid}, 32'h1);
    checkOutput("single_y_data",  {24'b0, busF.y_data},  32'h11);
    checkOutput("single_sel",     {31'b0, busF.sel},     32'h0);

    // Backpressure: hold 0x11 for three cycles while 0x22 waits
    applyStimulus(1'b0, 1'b1, 8'h22, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("bp_a_ready", {31'b0, busF.a_ready}, 32'h0);
      checkOutput("bp_b_ready", {31'b0, busF.b_ready}, 32'h0);
      tick();
      checkOutput("bp_y_data",  {24'b0, busF.y_data},  32'h11);
      checkOutput("bp_y_valid", {31'b0, busF.y_valid}, 32'h1);
    end
    applyStimulus(1'b0, 1'b1, 8'h22, 1'b0, 8'h00, 1'b1);
    checkOutput("bp_release_a_ready", {31'b0, busF.a_ready}, 32'h1);
    tick();
    checkOutput("bp_next_y_valid", {31'b0, busF.y_valid}, 32'h1);
    checkOutput("bp_next_y_data",  {24'b0, busF.y_data},  32'h22);

    // b-only word so that a is owed the first contended slot
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h33, 1'b1);
    checkOutput("bonly_b_ready", {31'b0, busF.b_ready}, 32'h1);
    tick();
    checkOutput("bonly_y_data", {24'b0, busF.y_data}, 32'h33);
    checkOutput("bonly_sel",    {31'b0, busF.sel},    32'h1);

    // Contention: round-robin should alternate AA, BB, AA, BB
    applyStimulus(1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("rr_a_ready", {31'b0, busF.a_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
      checkOutput("rr_both_ready", {31'b0, busF.a_ready & busF.b_ready}, 32'h0);
      tick();
      checkOutput("rr_y_data", {24'b0, busF.y_data}, (i % 2 == 0) ? 32'hAA : 32'hBB);
      checkOutput("rr_sel",    {31'b0, busF.sel},    (i % 2 == 0) ? 32'h0 : 32'h1);
    end

    // Drain: nothing offered while consumer is ready
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("drain_y_valid", {31'b0, busF.y_valid}, 32'h0);

    // Empty register accepts even with y_ready low
    applyStimulus(1'b0, 1'b1, 8'h44, 1'b0, 8'h00, 1'b0);
    checkOutput("empty_a_ready", {31'b0, busF.a_ready}, 32'h1);
    tick();
    checkOutput("empty_load_y_data", {24'b0, busF.y_data}, 32'h44);

    // b offers then withdraws before acceptance; history must still say a
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0);
    checkOutput("withdraw_b_ready", {31'b0, busF.b_ready}, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("withdraw_y_valid", {31'b0, busF.y_valid}, 32'h0);
    applyStimulus(1'b0, 1'b1, 8'h66, 1'b1, 8'h77, 1'b0);
    checkOutput("withdraw_tie_b_ready", {31'b0, busF.b_ready}, 32'h1);
    tick();
    checkOutput("withdraw_tie_y_data", {24'b0, busF.y_data}, 32'h77);
    checkOutput("withdraw_tie_sel",    {31'b0, busF.sel},    32'h1);

    // Reset mid-cycle while FULL: outputs clear before any clock edge
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midrst_y_valid", {31'b0, busF.y_valid}, 32'h0);
    checkOutput("midrst_sel",     {31'b0, busF.sel},     32'h0);
    checkOutput("midrst_y_data",  {24'b0, busF.y_data},  32'h0);
    checkOutput("midrst_b_ready", {31'b0, busF.b_ready}, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("postrst_tie_a_ready", {31'b0, busF.a_ready}, 32'h1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Fixed priority: four a words, b never granted
    applyStimulus(1'b1, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checkOutput("fixed_b_ready", {31'b0, busX.b_ready}, 32'h0);
      checkOutput("fixed_a_ready", {31'b0, busX.a_ready}, 32'h1);
      tick();
      checkOutput("fixed_y_data", {24'b0, busX.y_data}, 32'hAA);
      checkOutput("fixed_sel",    {31'b0, busX.sel},    32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
